// File: rtl/wb_commit_stage_if.sv
// MEM -> WB handshake bundle: valid/bus forward, allowin backward.
interface wb_commit_stage_if #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 6
);
    localparam int BUS_W = 4*XLEN + 23 + CAUSE_W;

    logic             ms_to_ws_valid;
    logic [BUS_W-1:0] ms_to_ws_bus;
    logic             ws_allowin;

    modport master (
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        output ws_allowin
    );
endinterface

// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: commits GPR and CSR writes, raises exceptions
// and ertn redirects, stalls on multi-cycle CSR reads, counts retirements.
module wb_commit_stage #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 6,
    parameter int CSR_LAT = 1,
    parameter int BUS_W   = 4*XLEN + 23 + CAUSE_W
) (
    input  logic                clk,
    input  logic                reset,
    wb_commit_stage_if.slave    ms,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic [4:0]          ws_to_ds_dest,
    output logic [XLEN-1:0]     ws_to_ds_value,
    output logic                csr_rd_req,
    output logic [13:0]         csr_num,
    input  logic [XLEN-1:0]     csr_rvalue,
    output logic                csr_we,
    output logic [XLEN-1:0]     csr_wmask,
    output logic [XLEN-1:0]     csr_wvalue,
    output logic                ex_valid,
    output logic [5:0]          ex_ecode,
    output logic [8:0]          ex_esubcode,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_vaddr,
    output logic                ertn_commit,
    input  logic [XLEN-1:0]     ex_entry,
    input  logic [XLEN-1:0]     era_entry,
    output logic                flush,
    output logic [XLEN-1:0]     flush_target,
    output logic                ws_csr_busy,
    output logic [63:0]         retire_cnt,
    output logic [31:0]         ex_cnt,
    output logic [XLEN-1:0]     debug_wb_pc,
    output logic [3:0]          debug_wb_rf_wen,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [XLEN-1:0]     debug_wb_rf_wdata
);
    // Bus field offsets, LSB upward (pc is the lowest field).
    localparam int PC_LO     = 0;
    localparam int RES_LO    = XLEN;
    localparam int DEST_LO   = 2*XLEN;
    localparam int GRWE_BIT  = 2*XLEN + 5;
    localparam int CAUSE_LO  = 2*XLEN + 6;
    localparam int NUM_LO    = CAUSE_LO + CAUSE_W;
    localparam int WMASK_LO  = NUM_LO + 14;
    localparam int CSRRD_BIT = WMASK_LO + XLEN;
    localparam int CSRWE_BIT = CSRRD_BIT + 1;
    localparam int ERTN_BIT  = CSRRD_BIT + 2;
    localparam int VADDR_LO  = CSRRD_BIT + 3;

    localparam int WAIT_W = (CSR_LAT < 1) ? 1 : $clog2(CSR_LAT + 1);
    localparam logic [WAIT_W-1:0] LAT_CNT = WAIT_W'(CSR_LAT);

    // Fixed-priority cause encoder: returns {ecode, esubcode}.
    function automatic logic [14:0] encode_cause(input logic [CAUSE_W-1:0] c);
        logic high;
        high = 1'b0;
        for (int i = 6; i < CAUSE_W; i++) high = high | c[i];
        if (c[5])      return {6'h00, 9'd0};
        else if (c[0]) return {6'h08, 9'd0};
        else if (c[4]) return {6'h0d, 9'd0};
        else if (c[3]) return {6'h0c, 9'd0};
        else if (c[1]) return {6'h0b, 9'd0};
        else if (c[2]) return {6'h09, 9'd0};
        else if (high) return {6'h0e, 9'd0};
        else           return 15'd0;
    endfunction

    logic [BUS_W-1:0]   bus;
    logic               ws_valid;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               ready_go;
    logic               commit;
    logic               exc;
    logic [14:0]        cause_code;
    logic [XLEN-1:0]    gpr_value;

    logic [XLEN-1:0]    bus_pc, bus_result, bus_wmask, bus_vaddr;
    logic [4:0]         bus_dest;
    logic               bus_gr_we, bus_csr_rd, bus_csr_we, bus_ertn;
    logic [CAUSE_W-1:0] bus_cause;
    logic [13:0]        bus_num;

    assign bus_pc     = bus[PC_LO +: XLEN];
    assign bus_result = bus[RES_LO +: XLEN];
    assign bus_dest   = bus[DEST_LO +: 5];
    assign bus_gr_we  = bus[GRWE_BIT];
    assign bus_cause  = bus[CAUSE_LO +: CAUSE_W];
    assign bus_num    = bus[NUM_LO +: 14];
    assign bus_wmask  = bus[WMASK_LO +: XLEN];
    assign bus_csr_rd = bus[CSRRD_BIT];
    assign bus_csr_we = bus[CSRWE_BIT];
    assign bus_ertn   = bus[ERTN_BIT];
    assign bus_vaddr  = bus[VADDR_LO +: XLEN];

    // An excepting csrrd never waits: its read result is discarded anyway.
    assign exc           = |bus_cause;
    assign ready_go      = !(bus_csr_rd && !exc) || (CSR_LAT == 0) || (wait_cnt == LAT_CNT);
    assign commit        = ws_valid && ready_go;
    assign ms.ws_allowin = !ws_valid || ready_go;
    assign flush         = commit && (exc || bus_ertn);
    assign cause_code    = encode_cause(bus_cause);
    assign gpr_value     = bus_csr_rd ? csr_rvalue : bus_result;

    // Stage occupancy; a flush drops whatever MEM offers in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              ws_valid <= 1'b0;
        else if (flush)         ws_valid <= 1'b0;
        else if (ms.ws_allowin) ws_valid <= ms.ms_to_ws_valid;
    end

    // Latch the MEM bus on acceptance; the data register has no reset.
    always_ff @(posedge clk) begin
        if (ms.ws_allowin && ms.ms_to_ws_valid && !flush) bus <= ms.ms_to_ws_bus;
    end

    // CSR read latency counter; restarts for every committed instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                              wait_cnt <= '0;
        else if (commit)                                        wait_cnt <= '0;
        else if (ws_valid && bus_csr_rd && !exc && !ready_go)   wait_cnt <= wait_cnt + 1'b1;
    end

    // Performance counters, wrapping silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= 64'd0;
            ex_cnt     <= 32'd0;
        end else begin
            if (commit && !exc) retire_cnt <= retire_cnt + 64'd1;
            if (flush)          ex_cnt     <= ex_cnt + 32'd1;
        end
    end

    // Commit-side outputs, all forced to zero while the stage is empty.
    always_comb begin
        rf_we          = 1'b0;
        rf_waddr       = 5'd0;
        rf_wdata       = '0;
        ws_to_ds_dest  = 5'd0;
        ws_to_ds_value = '0;
        csr_rd_req     = 1'b0;
        csr_num        = 14'd0;
        csr_we         = 1'b0;
        csr_wmask      = '0;
        csr_wvalue     = '0;
        ex_valid       = 1'b0;
        ex_ecode       = 6'd0;
        ex_esubcode    = 9'd0;
        ex_pc          = '0;
        ex_vaddr       = '0;
        ertn_commit    = 1'b0;
        flush_target   = '0;
        ws_csr_busy    = 1'b0;
        debug_wb_pc    = '0;
        if (ws_valid) begin
            rf_we        = commit && bus_gr_we && !exc;
            rf_waddr     = bus_dest;
            rf_wdata     = gpr_value;
            if (bus_gr_we && !exc) begin
                ws_to_ds_dest  = bus_dest;
                ws_to_ds_value = gpr_value;
            end
            csr_rd_req   = bus_csr_rd && !exc && !ready_go;
            csr_num      = bus_num;
            csr_we       = commit && bus_csr_we && !exc;
            csr_wmask    = bus_wmask;
            csr_wvalue   = bus_result;
            ex_valid     = commit && exc;
            ex_ecode     = cause_code[14:9];
            ex_esubcode  = cause_code[8:0];
            ex_pc        = bus_pc;
            ex_vaddr     = bus_vaddr;
            ertn_commit  = commit && bus_ertn && !exc;
            flush_target = exc ? ex_entry : era_entry;
            ws_csr_busy  = bus_csr_rd || bus_csr_we;
            debug_wb_pc  = bus_pc;
        end
    end

    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
endmodule
